// File: rtl/fp_add_sub_unit_if.sv
// fp_add_sub_unit_if: issue-side request and floating write-back bundle for the FP add/sub unit
interface fp_add_sub_unit_if;
  logic        in_valid;
  logic        in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [4:0]  in_dest;
  logic        busy;
  logic        out_valid;
  logic [31:0] out_result;
  logic [4:0]  out_dest;
  logic        out_write_floating;
  modport master (
    output in_valid, in_op, in_a, in_b, in_dest,
    input  busy, out_valid, out_result, out_dest, out_write_floating
  );
  modport slave (
    input  in_valid, in_op, in_a, in_b, in_dest,
    output busy, out_valid, out_result, out_dest, out_write_floating
  );
endinterface

// File: rtl/fp_add_sub_unit.sv
// fp_add_sub_unit: fixed-latency single-precision add/subtract, truncating, denormals flushed to zero
module fp_add_sub_unit #(
  parameter int          LATENCY     = 4,
  parameter logic [31:0] NAN_PATTERN = 32'h7FC00000
) (
  input logic           clk,
  input logic           rst_n,
  fp_add_sub_unit_if.slave bus
);
  typedef enum logic [2:0] {IDLE, UNPACK, ALIGN, ADD, NORM} state_t;
  state_t      state;
  logic        unused_latency;
  logic [31:0] ra, rb;
  logic        rop;
  logic [4:0]  rdest;
  logic        sa, sb, spec;
  logic [7:0]  ea, eb;
  logic [23:0] ma, mb;
  logic [31:0] spec_val;
  logic        sx, sub;
  logic [7:0]  ex;
  logic [26:0] mx, my;
  logic [27:0] sum;
  logic        valid_q;
  logic [31:0] result_q;
  logic [4:0]  dest_q;
  assign unused_latency = (LATENCY == 4);
  assign bus.busy = (state != IDLE);
  assign bus.out_valid = valid_q;
  assign bus.out_write_floating = valid_q;
  assign bus.out_result = result_q;
  assign bus.out_dest = dest_q;
  logic [7:0]  ea_n, eb_n;
  logic        sb_n, a_nan, b_nan, a_inf, b_inf;
  logic [31:0] spec_val_n;
  assign ea_n = ra[30:23];
  assign eb_n = rb[30:23];
  assign sb_n = rb[31] ^ rop;
  assign a_nan = (&ea_n) && (|ra[22:0]);
  assign b_nan = (&eb_n) && (|rb[22:0]);
  assign a_inf = (&ea_n) && !(|ra[22:0]);
  assign b_inf = (&eb_n) && !(|rb[22:0]);
  assign spec_val_n = (a_nan || b_nan || (a_inf && b_inf && (ra[31] != sb_n))) ? NAN_PATTERN :
                      a_inf ? {ra[31], 8'hFF, 23'h0} :
                      b_inf ? {sb_n, 8'hFF, 23'h0} : 32'h0;
  logic        swap;
  logic [7:0]  ey_n, diff;
  logic [26:0] yfull, yshift;
  logic        ylost;
  assign swap = {eb, mb} > {ea, ma};
  assign ey_n = swap ? ea : eb;
  assign diff = (swap ? eb : ea) - ey_n;
  assign yfull = {swap ? ma : mb, 3'b000};
  assign yshift = yfull >> diff;
  assign ylost = |(yfull & ((27'd1 << diff) - 27'd1));
  logic [4:0]  lz;
  logic [9:0]  e_norm;
  logic [22:0] frac;
  logic [31:0] res_n;
  // priority encoder: the highest set bit of the magnitude wins
  always_comb begin
    lz = '0;
    for (int i = 0; i < 27; i++) lz = sum[i] ? 5'(26 - i) : lz;
  end
  assign e_norm = sum[27] ? {2'b00, ex} + 10'd1 : {2'b00, ex} - {5'b0, lz};
  assign frac = sum[27] ? sum[26:4] : 23'((sum[26:0] << lz) >> 3);
  assign res_n = spec ? spec_val :
                 (sum == 28'd0) ? 32'h0 :
                 (e_norm[9] || e_norm == 10'd0) ? 32'h0 :
                 (e_norm >= 10'd255) ? {sx, 8'hFF, 23'h0} :
                 {sx, e_norm[7:0], frac};
  // control FSM and registered result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      valid_q  <= 1'b0;
      result_q <= 32'h0;
      dest_q   <= 5'h0;
    end else begin
      valid_q <= 1'b0;
      case (state)
        IDLE:    state <= bus.in_valid ? UNPACK : IDLE;
        UNPACK:  state <= ALIGN;
        ALIGN:   state <= ADD;
        ADD:     state <= NORM;
        NORM: begin
          state    <= IDLE;
          valid_q  <= 1'b1;
          result_q <= res_n;
          dest_q   <= rdest;
        end
        default: state <= IDLE;
      endcase
    end
  end
  // datapath stages advance one step per FSM state
  always_ff @(posedge clk) begin
    case (state)
      IDLE: if (bus.in_valid) begin
        ra    <= bus.in_a;
        rb    <= bus.in_b;
        rop   <= bus.in_op;
        rdest <= bus.in_dest;
      end
      UNPACK: begin
        sa       <= ra[31];
        sb       <= sb_n;
        ea       <= ea_n;
        eb       <= eb_n;
        ma       <= (ea_n == 8'd0) ? 24'h0 : {1'b1, ra[22:0]};
        mb       <= (eb_n == 8'd0) ? 24'h0 : {1'b1, rb[22:0]};
        spec     <= a_nan || b_nan || a_inf || b_inf || (ea_n == 8'd0 && eb_n == 8'd0);
        spec_val <= spec_val_n;
      end
      ALIGN: begin
        sx  <= swap ? sb : sa;
        ex  <= swap ? eb : ea;
        mx  <= {swap ? mb : ma, 3'b000};
        my  <= {yshift[26:1], yshift[0] | ylost};
        sub <= sa ^ sb;
      end
      ADD: sum <= sub ? {1'b0, mx} - {1'b0, my} : {1'b0, mx} + {1'b0, my};
      default: ;
    endcase
  end
endmodule

// File: tb/tb_fp_add_sub_unit.sv
// tb_fp_add_sub_unit: directed checks of latency, busy, results and reset behaviour
module tb_fp_add_sub_unit;
  logic clk = 1'b0;
  logic rst_n;
  int errors = 0;
  int checks = 0;
  fp_add_sub_unit_if bus();
  fp_add_sub_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic chk_idle_clear(input string tag);
    chk({tag, " busy"}, 32'(bus.busy), 32'd0);
    chk({tag, " valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, " wf"}, 32'(bus.out_write_floating), 32'd0);
    chk({tag, " result"}, bus.out_result, 32'h0);
    chk({tag, " dest"}, 32'(bus.out_dest), 32'd0);
  endtask
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic op, input logic [4:0] d, input logic [31:0] exp);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_op = op;
    bus.in_a = a;
    bus.in_b = b;
    bus.in_dest = d;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_a = 32'hFFFFFFFF;
    bus.in_b = 32'h0;
    bus.in_op = ~op;
    bus.in_dest = ~d;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk({tag, " busy"}, 32'(bus.busy), 32'd1);
      chk({tag, " early valid"}, 32'(bus.out_valid), 32'd0);
    end
    @(negedge clk);
    chk({tag, " valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, " wf"}, 32'(bus.out_write_floating), 32'd1);
    chk({tag, " busy done"}, 32'(bus.busy), 32'd0);
    chk({tag, " result"}, bus.out_result, exp);
    chk({tag, " dest"}, 32'(bus.out_dest), 32'(d));
    @(negedge clk);
    chk({tag, " valid drop"}, 32'(bus.out_valid), 32'd0);
    chk({tag, " wf drop"}, 32'(bus.out_write_floating), 32'd0);
    chk({tag, " result hold"}, bus.out_result, exp);
  endtask
  initial begin
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_op = 1'b0;
    bus.in_a = 32'h0;
    bus.in_b = 32'h0;
    bus.in_dest = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    chk_idle_clear("reset");
    @(negedge clk);
    rst_n = 1'b1;
    run_op("add12", 32'h3F99999A, 32'h3F99999A, 1'b0, 5'd3, 32'h4019999A);
    run_op("sub15_2", 32'h3FC00000, 32'h40000000, 1'b1, 5'd5, 32'hBF000000);
    run_op("sub_xx", 32'h3F99999A, 32'h3F99999A, 1'b1, 5'd6, 32'h00000000);
    run_op("ovf", 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 5'd8, 32'h7F800000);
    run_op("inf_inf", 32'h7F800000, 32'h7F800000, 1'b1, 5'd10, 32'h7FC00000);
    run_op("inf_num", 32'h3F800000, 32'hFF800000, 1'b1, 5'd11, 32'h7F800000);
    run_op("zero_zero", 32'h00000000, 32'h80000000, 1'b0, 5'd2, 32'h00000000);
    run_op("nan", 32'h7FC12345, 32'h3F800000, 1'b0, 5'd4, 32'h7FC00000);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_op = 1'b0;
    bus.in_a = 32'h3F800000;
    bus.in_b = 32'h40000000;
    bus.in_dest = 5'd1;
    @(posedge clk);
    #1;
    bus.in_a = 32'h40400000;
    bus.in_b = 32'h40000000;
    bus.in_dest = 5'd7;
    repeat (4) @(negedge clk);
    @(negedge clk);
    chk("b2b first valid", 32'(bus.out_valid), 32'd1);
    chk("b2b first result", bus.out_result, 32'h40400000);
    chk("b2b first dest", 32'(bus.out_dest), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("b2b second busy", 32'(bus.busy), 32'd1);
    chk("b2b first drop", 32'(bus.out_valid), 32'd0);
    chk("b2b first hold", bus.out_result, 32'h40400000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("b2b second early", 32'(bus.out_valid), 32'd0);
    end
    @(negedge clk);
    chk("b2b second valid", 32'(bus.out_valid), 32'd1);
    chk("b2b second result", bus.out_result, 32'h40A00000);
    chk("b2b second dest", 32'(bus.out_dest), 32'd7);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_a = 32'h3F800000;
    bus.in_b = 32'h40000000;
    bus.in_dest = 5'd9;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_idle_clear("mid reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("after reset no valid", 32'(bus.out_valid), 32'd0);
    end
    run_op("fresh", 32'h40400000, 32'h3F800000, 1'b1, 5'd12, 32'h40000000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fp_add_sub_unit.md
Name: fp_add_sub_unit

Overview:
- Multi-cycle IEEE-754 single-precision add/subtract unit in the EX stage of the floating-point path.
- Sits upstream of the floating-point register file: its result, destination and write-enable travel through EX/MEM and MEM/WB and become the floating write-back data, address and enable.
- Uses a fixed-latency FSM and a busy signal that stalls the issue stage while an operation is in flight.

Parameters:
- LATENCY, 4, cycles from accept to result-valid; fixed, documentation only, must equal the FSM depth.
- NAN_PATTERN, 32'h7FC00000, canonical quiet NaN returned for any invalid operation.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operation request from the ID/EX register
- in_op  input  1  0 = add (a+b), 1 = subtract (a-b)
- in_a  input  32  operand A, single precision
- in_b  input  32  operand B, single precision
- in_dest  input  5  destination floating register number
- busy  output  1  high while an operation is in flight; issue stage holds
- out_valid  output  1  one-cycle pulse, result valid
- out_result  output  32  single-precision result
- out_dest  output  5  destination register for out_result
- out_write_floating  output  1  write-enable toward EX/MEM; equals out_valid

Behaviour:
- Clock and reset
  - One clock.
  - Reset is asynchronous and active-low.
  - While rst_n = 0: state = IDLE, and busy, out_valid, out_write_floating, out_result and out_dest are all 0.
- Accept
  - An operation is accepted on a rising edge where in_valid = 1 and state = IDLE.
  - At accept, operands, op and dest are captured; later input changes are ignored.
  - in_valid while busy = 1 is ignored, not queued.
- busy: combinational, equals (state != IDLE).
- FSM: IDLE -> UNPACK -> ALIGN -> ADD -> NORM -> IDLE, one cycle per state, no data-dependent stalls.
  - UNPACK
    - Split sign, exponent and mantissa; insert the hidden 1.
    - Subtract is done by inverting B's sign.
    - Exponent 0 is treated as zero (denormals flushed to zero).
    - Classify NaN, Inf and zero.
  - ALIGN
    - Swap so the larger magnitude is X.
    - Shift the smaller mantissa right by the exponent difference, keeping 3 extra bits (guard, round, sticky).
    - A shift of 27 or more leaves only the sticky bit.
  - ADD
    - Equal signs: add mantissas.
    - Opposite signs: X minus Y.
    - Result sign is X's sign.
  - NORM
    - On carry-out, shift right by 1 and increment the exponent.
    - Otherwise shift left by the leading-zero count (single cycle, priority encoder) and decrement the exponent.
    - Truncate the extra bits (round toward zero).
    - Register the outputs.
- Output timing
  - With accept on edge N, out_valid and out_write_floating are high for exactly the cycle after edge N+4.
  - In that cycle state = IDLE, so a new accept may occur on the same edge that drops out_valid. Back-to-back throughput is one operation per 5 cycles.
  - out_result and out_dest hold their values until the next result.
- Special cases (highest priority first)
  - Either operand NaN -> NAN_PATTERN.
  - Inf combined with Inf of opposite effective sign -> NAN_PATTERN.
  - Any other case involving Inf -> Inf carrying that Inf's effective sign.
  - Exact zero result (including x - x) -> 32'h00000000.
  - Both inputs zero -> 32'h00000000.
  - Exponent overflow (>= 255) -> signed Inf.
  - Exponent underflow (<= 0 after normalization) -> 32'h00000000.
- Reset mid-operation: the in-flight operation is discarded and no out_valid is produced.

Test Plan:
- Reset, then accept in_a = 32'h3F99999A, in_b = 32'h3F99999A, op = add, dest = 3 -> busy high for 4 cycles; out_valid pulses once, 4 edges after accept; out_result = 32'h4019999A; out_dest = 3; out_write_floating = 1 in that cycle only.
- Accept 32'h3FC00000 - 32'h40000000 (1.5 - 2.0) -> out_result = 32'hBF000000.
- Accept 32'h3F99999A - 32'h3F99999A -> out_result = 32'h00000000.
- Accept 32'h7F7FFFFF + 32'h7F7FFFFF -> 32'h7F800000. Separately, 32'h7F800000 - 32'h7F800000 -> 32'h7FC00000.
- Two requests back to back, with in_valid held high throughout: first 32'h3F800000 + 32'h40000000; second presented while busy, with operands held stable until accepted -> first result 32'h40400000. Second is accepted on the edge that drops the first out_valid and produces its result 5 cycles later. Check that changing in_a while busy does not alter the first result.
- Accept an op, drive rst_n low for one cycle two edges later -> busy and outputs clear immediately, no out_valid pulse follows, and a fresh accept afterwards completes normally.
